// File: rtl/fifo4_ctrl.sv
`default_nettype none
//============================================================================
// Module      : fifo4_ctrl
// Description : Write arbiter and read sequencer for a 4-entry FIFO. It
//               round-robins two producers onto the FIFO write port and
//               serves one consumer with a request/acknowledge read.
// Revision    : 1.0 - initial release
//============================================================================
module fifo4_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         clr_n,
    input  logic                         req0,
    input  logic [WIDTH-1:0]             din0,
    input  logic                         req1,
    input  logic [WIDTH-1:0]             din1,
    output logic                         gnt0,
    output logic                         gnt1,
    input  logic                         rd_req,
    output logic                         rd_ack,
    output logic [WIDTH-1:0]             rd_data,
    output logic [WIDTH-1:0]             fifo_din,
    output logic                         fifo_write,
    output logic                         fifo_read,
    output logic                         fifo_clr,
    input  logic [WIDTH-1:0]             fifo_dout,
    input  logic                         fifo_empty,
    input  logic                         fifo_full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int                 c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [2:0] c_st_clear   = 3'd0;
    localparam logic [2:0] c_st_idle    = 3'd1;
    localparam logic [2:0] c_st_wr      = 3'd2;
    localparam logic [2:0] c_st_rd      = 3'd3;
    localparam logic [2:0] c_st_rd_wait = 3'd4;

    localparam logic c_op_rd = 1'b0;
    localparam logic c_op_wr = 1'b1;

    logic [2:0] r_state;
    logic       r_last_gnt;
    logic       r_last_op;

    logic w_wr_ok;
    logic w_rd_ok;
    logic w_pick1;
    logic w_do_wr;
    logic w_do_rd;

    // The shadow count guards against flags that lag the strobes by a cycle.
    assign w_wr_ok = (req0 | req1) & (count < c_depth) & ~fifo_full;
    assign w_rd_ok = rd_req & (count != '0) & ~fifo_empty;

    assign w_pick1 = req1 & (~req0 | ~r_last_gnt);
    assign w_do_wr = w_wr_ok & (~w_rd_ok | (r_last_op == c_op_rd));
    assign w_do_rd = w_rd_ok & ~w_do_wr;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state    <= c_st_clear;
            r_last_gnt <= 1'b1;
            r_last_op  <= c_op_rd;
            fifo_clr   <= 1'b1;
            count      <= '0;
            rd_data    <= '0;
            fifo_din   <= '0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rd_ack     <= 1'b0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
        end else begin
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            rd_ack     <= 1'b0;
            fifo_write <= 1'b0;
            fifo_read  <= 1'b0;
            fifo_clr   <= 1'b0;

            case (r_state)
                c_st_clear: begin
                    r_state <= c_st_idle;
                end

                // Strobes are registered on entry so they are high for the
                // whole cycle spent in WR / RD / RD_WAIT.
                c_st_idle: begin
                    if (w_do_wr) begin
                        fifo_din   <= w_pick1 ? din1 : din0;
                        r_last_gnt <= w_pick1;
                        gnt0       <= ~w_pick1;
                        gnt1       <= w_pick1;
                        fifo_write <= 1'b1;
                        if (count < c_depth) begin
                            count <= count + 1'b1;
                        end
                        r_last_op  <= c_op_wr;
                        r_state    <= c_st_wr;
                    end else if (w_do_rd) begin
                        fifo_read <= 1'b1;
                        if (count != '0) begin
                            count <= count - 1'b1;
                        end
                        r_last_op <= c_op_rd;
                        r_state   <= c_st_rd;
                    end
                end

                c_st_wr: begin
                    r_state <= c_st_idle;
                end

                // The FIFO presents its head entry on dout until the pop edge.
                c_st_rd: begin
                    rd_data <= fifo_dout;
                    rd_ack  <= 1'b1;
                    r_state <= c_st_rd_wait;
                end

                c_st_rd_wait: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_clear;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo4_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_fifo4_ctrl
// Description : Self-checking bench for fifo4_ctrl with a show-ahead FIFO
//               model and queue-based expected results.
// Revision    : 1.0 - initial release
//============================================================================
module tb_fifo4_ctrl;

    logic       clk    = 1'b0;
    logic       clr_n  = 1'b0;
    logic       req0   = 1'b0;
    logic       req1   = 1'b0;
    logic       rd_req = 1'b0;
    logic [3:0] din0   = 4'h0;
    logic [3:0] din1   = 4'h0;
    logic       gnt0, gnt1, rd_ack, fifo_write, fifo_read, fifo_clr;
    logic       fifo_empty, fifo_full;
    logic [3:0] rd_data, fifo_din, fifo_dout;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] exp_din_q[$];
    int         exp_src_q[$];
    logic [3:0] exp_rd_q[$];
    logic [2:0] exp_cnt_q[$];
    byte        exp_op_q[$];

    fifo4_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .clr_n(clr_n),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data),
        .fifo_din(fifo_din), .fifo_write(fifo_write), .fifo_read(fifo_read),
        .fifo_clr(fifo_clr), .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .count(count)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO model; the override bits force the flags on their own.
    logic [3:0] fmem [0:3];
    int         f_wp = 0, f_rp = 0, f_n = 0;
    bit         ovr_full = 1'b0, ovr_empty = 1'b0;

    initial for (int i = 0; i < 4; i++) fmem[i] = 4'h0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            f_wp <= 0; f_rp <= 0; f_n <= 0;
        end else begin
            if (fifo_write && f_n < 4) begin
                fmem[f_wp[1:0]] <= fifo_din;
                f_wp <= (f_wp + 1) % 4;
            end
            if (fifo_read && f_n > 0) f_rp <= (f_rp + 1) % 4;
            f_n <= f_n + ((fifo_write && f_n < 4) ? 1 : 0) - ((fifo_read && f_n > 0) ? 1 : 0);
        end
    end

    assign fifo_dout  = fmem[f_rp[1:0]];
    assign fifo_empty = (f_n == 0) | ovr_empty;
    assign fifo_full  = (f_n == 4) | ovr_full;

    task automatic do_reset();
        clr_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Producer handshake: hold req until the grant shows, then drop it.
    task automatic push_word(input int src, input logic [3:0] d, output bit ok);
        ok = 1'b0;
        if (src == 0) begin req0 = 1'b1; din0 = d; end
        else          begin req1 = 1'b1; din1 = d; end
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if ((src == 0 && gnt0) || (src == 1 && gnt1)) ok = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
            n_cmp++;
            if (fifo_clr !== 1'b1) begin n_bad++; $display("FAIL reset_clr: got %b want 1", fifo_clr); end
            n_cmp++;
            if ({gnt0, gnt1, rd_ack, fifo_write, fifo_read} !== 5'b0) begin
                n_bad++; $display("FAIL reset_strobes: got %b want 00000", {gnt0, gnt1, rd_ack, fifo_write, fifo_read});
            end
        end
        n_cmp++;
        if ({rd_data, fifo_din} !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", {rd_data, fifo_din}); end
        clr_n = 1'b1;
        #1;
        n_cmp++;
        if (fifo_clr !== 1'b1) begin n_bad++; $display("FAIL release_clr_hold: got %b want 1", fifo_clr); end
        @(negedge clk);
        n_cmp++;
        if (fifo_clr !== 1'b0) begin n_bad++; $display("FAIL release_clr_drop: got %b want 0", fifo_clr); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({fifo_clr, gnt0, gnt1, rd_ack, fifo_write, fifo_read, count} !== 9'b0) begin
                n_bad++; $display("FAIL idle_quiet: got %b want 0", {fifo_clr, gnt0, gnt1, rd_ack, fifo_write, fifo_read, count});
            end
        end
    endtask

    task automatic test_single();
        bit extra = 1'b0;
        do_reset();
        exp_din_q.push_back(4'b1010);
        req0 = 1'b1; din0 = 4'b1010;
        @(negedge clk);
        n_cmp++;
        if ({gnt0, gnt1, fifo_write} !== 3'b101) begin
            n_bad++; $display("FAIL single_grant: got %b want 101", {gnt0, gnt1, fifo_write});
        end
        req0 = 1'b0;
        n_cmp++;
        if (fifo_din !== exp_din_q.pop_front()) begin n_bad++; $display("FAIL single_data: got %h want a", fifo_din); end
        n_cmp++;
        if (count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", count); end
        repeat (5) begin
            @(negedge clk);
            if (gnt0 | gnt1 | fifo_write) extra = 1'b1;
        end
        n_cmp++;
        if (extra !== 1'b0) begin n_bad++; $display("FAIL single_extra_write: got %b want 0", extra); end
    endtask

    task automatic test_round_robin();
        int         last_g = -1;
        int         src;
        logic [2:0] want;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            exp_src_q.push_back(0); exp_din_q.push_back(4'h3);
            exp_src_q.push_back(1); exp_din_q.push_back(4'hC);
        end
        req0 = 1'b1; req1 = 1'b1; din0 = 4'h3; din1 = 4'hC;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (gnt0 || gnt1 || fifo_write) begin
                if (exp_src_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rr_extra_grant: got %b want none", {gnt0, gnt1, fifo_write});
                end else begin
                    src  = exp_src_q.pop_front();
                    want = (src == 0) ? 3'b101 : 3'b011;
                    n_cmp++;
                    if ({gnt0, gnt1, fifo_write} !== want) begin
                        n_bad++; $display("FAIL rr_grant_order: got %b want %b", {gnt0, gnt1, fifo_write}, want);
                    end
                    n_cmp++;
                    if (fifo_din !== exp_din_q[0]) begin
                        n_bad++; $display("FAIL rr_data: got %h want %h", fifo_din, exp_din_q[0]);
                    end
                    void'(exp_din_q.pop_front());
                    if (last_g > 0) begin
                        n_cmp++;
                        if (cyc - last_g !== 2) begin n_bad++; $display("FAIL rr_spacing: got %0d want 2", cyc - last_g); end
                    end
                    last_g = cyc;
                end
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        n_cmp++;
        if (exp_src_q.size() !== 0) begin n_bad++; $display("FAIL rr_missing: got %0d left want 0", exp_src_q.size()); end
        n_cmp++;
        if (count !== 3'd4) begin n_bad++; $display("FAIL rr_count: got %0d want 4", count); end
        exp_src_q.delete(); exp_din_q.delete();
    endtask

    task automatic test_read_path();
        bit ok;
        bit prev_rd = 1'b0;
        int last_a  = -1;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            push_word(0, 4'(i), ok);
            n_cmp++;
            if (!ok) begin n_bad++; $display("FAIL rp_fill_timeout: got no gnt0 want gnt0 for %0d", i); end
        end
        n_cmp++;
        if (count !== 3'd3) begin n_bad++; $display("FAIL rp_fill_count: got %0d want 3", count); end
        for (int i = 1; i <= 3; i++) begin
            exp_rd_q.push_back(4'(i));
            exp_cnt_q.push_back(3'(3 - i));
        end
        rd_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (fifo_read) begin
                if (exp_cnt_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL rp_extra_read: got fifo_read=1 want 0");
                end else begin
                    n_cmp++;
                    if (count !== exp_cnt_q[0]) begin n_bad++; $display("FAIL rp_count: got %0d want %0d", count, exp_cnt_q[0]); end
                    void'(exp_cnt_q.pop_front());
                end
            end
            if (rd_ack) begin
                n_cmp++;
                if (prev_rd !== 1'b1) begin n_bad++; $display("FAIL rp_read_lead: got %b want 1", prev_rd); end
                if (exp_rd_q.size() == 0) begin
                    n_cmp++; n_bad++; $display("FAIL rp_extra_ack: got rd_ack=1 want 0");
                end else begin
                    n_cmp++;
                    if (rd_data !== exp_rd_q[0]) begin n_bad++; $display("FAIL rp_data: got %h want %h", rd_data, exp_rd_q[0]); end
                    void'(exp_rd_q.pop_front());
                end
                if (last_a > 0) begin
                    n_cmp++;
                    if (cyc - last_a !== 3) begin n_bad++; $display("FAIL rp_spacing: got %0d want 3", cyc - last_a); end
                end
                last_a = cyc;
            end
            prev_rd = fifo_read;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (exp_rd_q.size() !== 0) begin n_bad++; $display("FAIL rp_missing_ack: got %0d left want 0", exp_rd_q.size()); end
        n_cmp++;
        if (count !== 3'd0) begin n_bad++; $display("FAIL rp_final_count: got %0d want 0", count); end
        exp_rd_q.delete(); exp_cnt_q.delete();
    endtask

    task automatic test_contention();
        bit  ok;
        int  n_g = 0, n_a = 0;
        byte op;
        do_reset();
        for (int i = 1; i <= 3; i++) push_word(0, 4'(i), ok);
        rd_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (rd_ack) ok = 1'b1;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (!ok || rd_data !== 4'h1) begin n_bad++; $display("FAIL ct_setup_read: got %h ack=%b want 1", rd_data, ok); end
        exp_op_q = '{8'h57, 8'h52, 8'h57, 8'h52};
        exp_rd_q = '{4'h2, 4'h3};
        req1 = 1'b1; din1 = 4'h5; rd_req = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (count < 3'd2 || count > 3'd3) begin n_bad++; $display("FAIL ct_count_range: got %0d want 2..3", count); end
            if (fifo_write || fifo_read) begin
                op = (exp_op_q.size() == 0) ? 8'h2D : exp_op_q.pop_front();
                n_cmp++;
                if ((fifo_write && op !== 8'h57) || (fifo_read && op !== 8'h52) || (fifo_write && fifo_read)) begin
                    n_bad++; $display("FAIL ct_order: got wr=%b rd=%b want %c", fifo_write, fifo_read, op);
                end
            end
            if (gnt1) begin
                n_g++;
                if (n_g == 2) req1 = 1'b0;
            end
            if (rd_ack) begin
                n_cmp++;
                if (exp_rd_q.size() == 0 || rd_data !== exp_rd_q[0]) begin
                    n_bad++; $display("FAIL ct_data: got %h want queued value", rd_data);
                end
                if (exp_rd_q.size() != 0) void'(exp_rd_q.pop_front());
                n_a++;
                if (n_a == 2) rd_req = 1'b0;
            end
        end
        req1 = 1'b0; rd_req = 1'b0;
        n_cmp++;
        if (exp_op_q.size() !== 0) begin n_bad++; $display("FAIL ct_missing_ops: got %0d left want 0", exp_op_q.size()); end
        n_cmp++;
        if (count !== 3'd2) begin n_bad++; $display("FAIL ct_final_count: got %0d want 2", count); end
        exp_op_q.delete(); exp_rd_q.delete();
    endtask

    task automatic test_flag_block();
        bit seen = 1'b0;
        bit got  = 1'b0;
        do_reset();
        ovr_full = 1'b1; req0 = 1'b1; din0 = 4'h7;
        repeat (6) begin
            @(negedge clk);
            if (gnt0 | fifo_write) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL full_blocks_write: got %b want 0", seen); end
        ovr_full = 1'b0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (gnt0) begin got = 1'b1; req0 = 1'b0; end
        end
        req0 = 1'b0;
        n_cmp++;
        if (!got || fifo_din !== 4'h7) begin n_bad++; $display("FAIL full_release_write: got gnt=%b din=%h want 1 7", got, fifo_din); end
        ovr_empty = 1'b1; rd_req = 1'b1; seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (fifo_read | rd_ack) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL empty_blocks_read: got %b want 0", seen); end
        ovr_empty = 1'b0; got = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (rd_ack) got = 1'b1;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (!got || rd_data !== 4'h7) begin n_bad++; $display("FAIL empty_release_read: got ack=%b data=%h want 1 7", got, rd_data); end
    endtask

    task automatic test_reset_mid_read();
        bit ok;
        bit hit = 1'b0;
        bit ack_seen = 1'b0;
        do_reset();
        push_word(0, 4'h9, ok);
        rd_req = 1'b1; ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if (rd_ack) ok = 1'b1;
        end
        rd_req = 1'b0;
        n_cmp++;
        if (!ok || rd_data !== 4'h9) begin n_bad++; $display("FAIL mr_first_read: got %h want 9", rd_data); end
        push_word(0, 4'h6, ok);
        rd_req = 1'b1;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if (fifo_read) hit = 1'b1;
        end
        // Reset lands on the edge that would have entered RD_WAIT.
        clr_n = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (!hit || rd_ack !== 1'b0) begin n_bad++; $display("FAIL mr_no_ack: got %b read_seen=%b want 0", rd_ack, hit); end
        n_cmp++;
        if (rd_data !== 4'h0) begin n_bad++; $display("FAIL mr_data: got %h want 0", rd_data); end
        n_cmp++;
        if (count !== 3'd0) begin n_bad++; $display("FAIL mr_count: got %0d want 0", count); end
        n_cmp++;
        if (fifo_clr !== 1'b1) begin n_bad++; $display("FAIL mr_clr: got %b want 1", fifo_clr); end
        clr_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rd_ack) ack_seen = 1'b1;
        end
        n_cmp++;
        if (ack_seen !== 1'b0 || fifo_clr !== 1'b0) begin
            n_bad++; $display("FAIL mr_after: got ack=%b clr=%b want 0 0", ack_seen, fifo_clr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_read_path();
        test_contention();
        test_flag_block();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
